fetch_stage: RTL

- IF stage of the 5-stage MIPS pipeline: owns the PC, drives the word address to instruction memory, and registers the fetched instruction into the IF/ID register consumed by the decode stage.
- Adds what the bare pipeline lacks: stall hold, branch-redirect flush and halt-instruction drain detection.
- A `halted` flag tells the testbench when the program has retired.

---
 rtl/fetch_stage.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, addresses instruction memory and fills the IF/ID register.
// Optional FETCH_PERF_EN macro adds saturating fetch/stall/flush counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ADDR_W       = 16,
    parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr_d,
    output logic [31:0]       pc_d,
    output logic [31:0]       pc_plus4_d,
    output logic              valid_d,
    output logic              halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stalls,
    output logic [31:0]       perf_flushes
`endif
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetchState_e;

    fetchState_e      state_r, stateNext_s;
    logic [31:0]      pcF_r, pcNext_s;
    logic [CNT_W-1:0] drainCnt_r, drainCntNext_s;
    logic [31:0]      instrNext_s, pcDNext_s, pcPlus4Next_s;
    logic             validNext_s, haltedNext_s;

    assign imem_addr = pcF_r[ADDR_W+1:2];

    // Next-state and IF/ID next-value selection: redirect > stall > normal fetch/drain.
    always_comb begin
        stateNext_s    = state_r;
        pcNext_s       = pcF_r;
        drainCntNext_s = drainCnt_r;
        instrNext_s    = instr_d;
        pcDNext_s      = pc_d;
        pcPlus4Next_s  = pc_plus4_d;
        validNext_s    = valid_d;
        haltedNext_s   = halted;
        case (state_r)
            RUN, DRAIN: begin
                if (redirect_valid) begin
                    // Flushing also cancels a halt fetched on the wrong path.
                    pcNext_s       = {redirect_pc[31:2], 2'b00};
                    instrNext_s    = 32'h0000_0000;
                    validNext_s    = 1'b0;
                    stateNext_s    = RUN;
                    drainCntNext_s = '0;
                end else if (stall) begin
                    pcNext_s    = pcF_r;
                    stateNext_s = state_r;
                end else if (state_r == RUN) begin
                    instrNext_s   = imem_rdata;
                    pcDNext_s     = pcF_r;
                    pcPlus4Next_s = pcF_r + 32'd4;
                    validNext_s   = 1'b1;
                    if (imem_rdata == HALT_INSTR) begin
                        stateNext_s    = DRAIN;
                        drainCntNext_s = '0;
                    end else begin
                        pcNext_s = pcF_r + 32'd4;
                    end
                end else begin
                    instrNext_s    = 32'h0000_0000;
                    validNext_s    = 1'b0;
                    drainCntNext_s = drainCnt_r + CNT_W'(1);
                    if (drainCnt_r == DRAIN_LAST) begin
                        stateNext_s  = HALTED;
                        haltedNext_s = 1'b1;
                    end else begin
                        stateNext_s = DRAIN;
                    end
                end
            end
            HALTED: begin
                validNext_s = 1'b0;
            end
            default: begin
                stateNext_s    = RUN;
                instrNext_s    = 32'h0000_0000;
                validNext_s    = 1'b0;
                drainCntNext_s = '0;
            end
        endcase
    end

    // PC, FSM and IF/ID registers share the pipeline's falling edge.
    always_ff @(negedge clk) begin
        if (reset) begin
            state_r    <= RUN;
            pcF_r      <= RESET_PC;
            drainCnt_r <= '0;
            instr_d    <= 32'h0000_0000;
            pc_d       <= 32'h0000_0000;
            pc_plus4_d <= 32'h0000_0004;
            valid_d    <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state_r    <= stateNext_s;
            pcF_r      <= pcNext_s;
            drainCnt_r <= drainCntNext_s;
            instr_d    <= instrNext_s;
            pc_d       <= pcDNext_s;
            pc_plus4_d <= pcPlus4Next_s;
            valid_d    <= validNext_s;
            halted     <= haltedNext_s;
        end
    end

`ifdef FETCH_PERF_EN
    logic fetchInc_s, stallInc_s, flushInc_s;

    function automatic logic [31:0] satInc(input logic [31:0] value, input logic enable);
        return (enable && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
    endfunction

    assign fetchInc_s = (state_r == RUN) && !redirect_valid && !stall;
    assign stallInc_s = stall && !redirect_valid && (state_r != HALTED);
    assign flushInc_s = redirect_valid && (state_r != HALTED);

    // Saturating event counters; all enables are already false once halted.
    always_ff @(negedge clk) begin
        if (reset) begin
            perf_fetched <= 32'h0000_0000;
            perf_stalls  <= 32'h0000_0000;
            perf_flushes <= 32'h0000_0000;
        end else begin
            perf_fetched <= satInc(perf_fetched, fetchInc_s);
            perf_stalls  <= satInc(perf_stalls, stallInc_s);
            perf_flushes <= satInc(perf_flushes, flushInc_s);
        end
    end
`endif

endmodule
